// File: rtl/img_reader.sv
// img_reader: scans img_mem in raster order once per start request and
// re-emits the frame as a valid/ready pixel stream with position tags.
module img_reader #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned PIXELS     = IMG_WIDTH * IMG_HEIGHT,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AddrW = $clog2(PIXELS) + 1,
  localparam int unsigned HcntW = $clog2(IMG_WIDTH),
  localparam int unsigned VcntW = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  w_busy,
  output logic [AddrW-1:0]      r_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [HcntW-1:0]      pix_hcount,
  output logic [VcntW-1:0]      pix_vcount,
  output logic                  pix_eol,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(PIXELS - 1);
  localparam logic [HcntW-1:0] LastCol  = HcntW'(IMG_WIDTH - 1);
  localparam logic [VcntW-1:0] LastRow  = VcntW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {StIdle, StWait, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [AddrW-1:0]      addr_q, addr_d;    // next address to issue
  logic [AddrW-1:0]      raddr_q, raddr_d;  // last issued address, held on r_addr
  logic [RD_LATENCY-1:0] ifl_q, ifl_d;      // issue flags travelling with the read latency
  logic [PtrW:0]         wptr_q, wptr_d;
  logic [PtrW:0]         rptr_q, rptr_d;
  logic [PtrW:0]         fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [HcntW-1:0]      hcnt_q, hcnt_d;
  logic [VcntW-1:0]      vcnt_q, vcnt_d;
  logic                  issue, push, pop, credit_ok;

  // FIFO occupancy, credit and stream outputs
  always_comb begin
    fifo_cnt   = wptr_q - rptr_q;
    // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
    credit_ok  = ($countones(ifl_q) + int'(fifo_cnt)) < int'(FIFO_DEPTH);
    push       = ifl_q[RD_LATENCY-1];
    pix_valid  = (fifo_cnt != '0);
    pix_data   = fifo_q[rptr_q[PtrW-1:0]];
    pop        = pix_valid & pix_ready;
    pix_hcount = hcnt_q;
    pix_vcount = vcnt_q;
    pix_eol    = pix_valid & (hcnt_q == LastCol);
    pix_last   = pix_valid & (hcnt_q == LastCol) & (vcnt_q == LastRow);
    busy       = (state_q == StWait) || (state_q == StRead) || (state_q == StDrain);
    done       = (state_q == StDone);
    r_addr     = issue ? addr_q : raddr_q;
  end

  // Control FSM: next state and read issue
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = w_busy ? StWait : StRead;
      StWait:  if (!w_busy) state_d = StRead;
      StRead: begin
        issue = !w_busy && credit_ok;
        if (issue && (addr_q == LastAddr)) state_d = StDrain;
      end
      StDrain: if (pop && pix_last && (ifl_q == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next-state for address, in-flight tracker, FIFO pointers and output counters
  always_comb begin
    addr_d  = addr_q;
    raddr_d = raddr_q;
    if (state_q == StIdle) begin
      addr_d = '0;
    end else if (issue) begin
      addr_d  = addr_q + AddrW'(1);
      raddr_d = addr_q;
    end
    ifl_d    = ifl_q << 1;
    ifl_d[0] = issue;
    wptr_d   = wptr_q + (PtrW + 1)'(push);
    rptr_d   = rptr_q + (PtrW + 1)'(pop);
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (pop) begin
      if (hcnt_q == LastCol) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == LastRow) ? '0 : vcnt_q + VcntW'(1);
      end else begin
        hcnt_d = hcnt_q + HcntW'(1);
      end
    end
  end

  // State registers; async reset abandons any frame in progress
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      raddr_q <= '0;
      ifl_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      ifl_q   <= ifl_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PtrW-1:0]] <= mem_dout;
  end

endmodule

// File: tb/tb_img_reader.sv
// Bench for img_reader: 4x3 frame, one DUT with read latency 1 and one with
// latency 3 sharing all stimulus; memory models return data = address.
module tb_img_reader;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned N  = W * H;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = $clog2(N) + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    h;
    logic [1:0]    v;
    logic          eol;
    logic          last;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst, start, w_busy, pix_ready;
  logic [AW-1:0] r_addr_a, r_addr_b;
  logic [DW-1:0] mem_a, mem_b, p1_b, p2_b;
  logic pix_valid_a, pix_eol_a, pix_last_a, busy_a, done_a;
  logic pix_valid_b, pix_eol_b, pix_last_b, busy_b, done_b;
  logic [DW-1:0] pix_data_a, pix_data_b;
  logic [1:0] pix_hcount_a, pix_vcount_a, pix_hcount_b, pix_vcount_b;

  img_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .RD_LATENCY(1),
               .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start), .w_busy(w_busy), .r_addr(r_addr_a),
    .mem_dout(mem_a), .pix_valid(pix_valid_a), .pix_ready(pix_ready),
    .pix_data(pix_data_a), .pix_hcount(pix_hcount_a), .pix_vcount(pix_vcount_a),
    .pix_eol(pix_eol_a), .pix_last(pix_last_a), .busy(busy_a), .done(done_a)
  );

  img_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .RD_LATENCY(3),
               .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start), .w_busy(w_busy), .r_addr(r_addr_b),
    .mem_dout(mem_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready),
    .pix_data(pix_data_b), .pix_hcount(pix_hcount_b), .pix_vcount(pix_vcount_b),
    .pix_eol(pix_eol_b), .pix_last(pix_last_b), .busy(busy_b), .done(done_b)
  );

  // Memory models: data = address, latency 1 and 3
  always @(posedge clk) begin
    mem_a <= DW'(r_addr_a);
    p1_b  <= DW'(r_addr_b);
    p2_b  <= p1_b;
    mem_b <= p2_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  pix_t exp_a[$];
  pix_t exp_b[$];
  bit   timed = 1'b0;
  int   t0    = 0;
  int   k;
  bit   hold_v[2];
  pix_t hold_p[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    pix_t e;
    for (int i = 0; i < int'(N); i++) begin
      e.d    = DW'(i);
      e.h    = 2'(i % W);
      e.v    = 2'(i / W);
      e.eol  = ((i % W) == W - 1);
      e.last = (i == N - 1);
      exp_a.push_back(e);
      exp_b.push_back(e);
    end
  endtask

  // Start pulse in "cycle 0"; returns at cycle 1 plus 1 time unit
  task automatic do_start(input bit tm);
    tick();
    start = 1'b1;
    push_frame();
    if (tm) begin
      t0    = cyc;
      timed = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy_a || busy_b) && n < 300) begin
      tick();
      n++;
    end
    chk("wait_done", 32'(busy_a || busy_b), 32'd0);
    repeat (3) tick();
  endtask

  task automatic mon(input int p, input string nm, input logic v, input pix_t got);
    pix_t e;
    if (hold_v[p]) chk({"hold_", nm}, 32'({v, got}), 32'({1'b1, hold_p[p]}));
    if (v && pix_ready) begin
      e = 'x;
      if (p == 0 && exp_a.size() > 0) e = exp_a.pop_front();
      else if (p == 1 && exp_b.size() > 0) e = exp_b.pop_front();
      chk({"pix_", nm}, 32'(got), 32'(e));
    end
    hold_v[p] = v && !pix_ready;
    hold_p[p] = got;
  endtask

  // Monitor: scoreboard pops, stall stability, and cycle-exact timing of dut_a
  initial begin
    hold_v[0] = 1'b0;
    hold_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        hold_v[0] = 1'b0;
        hold_v[1] = 1'b0;
      end else begin
        mon(0, "a", pix_valid_a,
            {pix_data_a, pix_hcount_a, pix_vcount_a, pix_eol_a, pix_last_a});
        mon(1, "b", pix_valid_b,
            {pix_data_b, pix_hcount_b, pix_vcount_b, pix_eol_b, pix_last_b});
        if (timed) begin
          k = cyc - t0;
          chk("t_valid", 32'(pix_valid_a), 32'(k >= 3 && k <= 14));
          if (k >= 1) chk("t_busy", 32'(busy_a), 32'(k <= 14));
          chk("t_done", 32'(done_a), 32'(k == 15));
          if (k >= 16) timed = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; w_busy = 1'b0; pix_ready = 1'b1;
    #1;
    chk("rst_a", 32'({pix_valid_a, busy_a, done_a, pix_hcount_a, pix_vcount_a, pix_eol_a,
                      pix_last_a, r_addr_a}), 32'd0);
    chk("rst_b", 32'({pix_valid_b, busy_b, done_b, pix_hcount_b, pix_vcount_b, pix_eol_b,
                      pix_last_b, r_addr_b}), 32'd0);
    repeat (2) tick();
    n_rst = 1'b1;
    tick();

    // Basic frame with exact timing
    do_start(1'b1);
    wait_done();

    // w_busy high for 10 cycles around start
    w_busy = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wait_a", 32'({busy_a, pix_valid_a, r_addr_a}), 32'({1'b1, 1'b0, AW'(N - 1)}));
      chk("wait_b", 32'({busy_b, pix_valid_b, r_addr_b}), 32'({1'b1, 1'b0, AW'(N - 1)}));
      tick();
    end
    w_busy = 1'b0;
    t0     = cyc;
    timed  = 1'b1;
    wait_done();

    // Backpressure 1,0,0,1
    do_start(1'b0);
    for (int i = 0; i < 300 && (busy_a || busy_b); i++) begin
      pix_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    pix_ready = 1'b1;
    wait_done();

    // Long stall: credit limits issue to four reads
    pix_ready = 1'b0;
    do_start(1'b0);
    repeat (18) tick();
    @(negedge clk);
    chk("stall_a", 32'({pix_valid_a, r_addr_a}), 32'({1'b1, AW'(3)}));
    chk("stall_b", 32'({pix_valid_b, r_addr_b}), 32'({1'b1, AW'(3)}));
    tick();
    pix_ready = 1'b1;
    wait_done();

    // w_busy pulse after address 5 issued
    do_start(1'b0);
    repeat (6) tick();
    w_busy = 1'b1;
    @(negedge clk);
    chk("pause_addr", 32'(r_addr_a), 32'd5);
    repeat (4) tick();
    @(negedge clk);
    chk("pause_end", 32'({pix_valid_a, r_addr_a}), 32'({1'b0, AW'(5)}));
    tick();
    w_busy = 1'b0;
    wait_done();

    // Async reset while pixel 6 is pending, then a fresh frame
    do_start(1'b0);
    repeat (8) tick();
    chk("pend6", 32'({pix_valid_a, pix_data_a}), 32'({1'b1, 8'd6}));
    #1;
    n_rst = 1'b0;
    #1;
    chk("rst6_a", 32'({pix_valid_a, busy_a, done_a, pix_hcount_a, pix_vcount_a, pix_eol_a,
                       pix_last_a, r_addr_a}), 32'd0);
    chk("rst6_b", 32'({pix_valid_b, busy_b, done_b, pix_hcount_b, pix_vcount_b, pix_eol_b,
                       pix_last_b, r_addr_b}), 32'd0);
    exp_a.delete();
    exp_b.delete();
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    do_start(1'b0);
    wait_done();

    chk("left_a", 32'(exp_a.size()), 32'd0);
    chk("left_b", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_reader.md
Name: img_reader

Overview:
- Read-side counterpart to the frame buffer `img_mem`, which the camera path writes.
- On a start request it waits for any frame write to finish, then scans `img_mem` in raster order by driving its read address.
- It re-emits the frame as a valid/ready pixel stream tagged with hcount/vcount and end-of-line/end-of-frame flags, for downstream processing or display.

Parameters:
- IMG_WIDTH, 640, pixels per line.
- IMG_HEIGHT, 480, lines per frame.
- PIXELS, IMG_WIDTH*IMG_HEIGHT, pixels per frame.
- DATA_WIDTH, 8, pixel width.
- RD_LATENCY, 1, cycles from r_addr driven to mem_dout valid (>=1).
- FIFO_DEPTH, 4, output buffer entries (>= RD_LATENCY+1, power of two).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  request one frame readout; sampled only in IDLE.
- w_busy  in  1  img_mem write in progress.
- r_addr  out  $clog2(PIXELS)+1  read address to img_mem.
- mem_dout  in  DATA_WIDTH  img_mem read data, RD_LATENCY after r_addr.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts pixel.
- pix_data  out  DATA_WIDTH  pixel value.
- pix_hcount  out  $clog2(IMG_WIDTH)  column of pix_data.
- pix_vcount  out  $clog2(IMG_HEIGHT)  line of pix_data.
- pix_eol  out  1  pix_hcount==IMG_WIDTH-1.
- pix_last  out  1  last pixel of frame.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (n_rst=0, async): state=IDLE; r_addr=0; FIFO empty; in-flight tracker cleared.
  - Outputs: pix_valid=0, busy=0, done=0, pix_hcount=0, pix_vcount=0, pix_eol=0, pix_last=0.
  - Reset mid-frame abandons the frame with no done pulse.
- States and transitions:
  - IDLE: start=1 & w_busy=0 -> READ; start=1 & w_busy=1 -> WAIT. busy goes high the cycle after start is accepted.
  - WAIT: remain while w_busy=1; w_busy=0 -> READ.
  - READ: issue a read in any cycle where w_busy=0 and (in_flight + fifo_count) < FIFO_DEPTH.
    - An issue drives r_addr = next address, then increments the address.
    - After issuing address PIXELS-1 -> DRAIN.
  - DRAIN: no issues. When in_flight=0, the FIFO is empty and the last handshake is done -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Start handling: start is ignored outside IDLE, and start held high re-triggers only after returning to IDLE.
- w_busy rising during READ pauses issuing. Reads already in flight still complete and are buffered. Issuing resumes at the same address.
- In-flight tracking: an RD_LATENCY-deep shift register of issue flags. When a flag emerges, mem_dout is pushed into the FIFO. The credit check guarantees the FIFO never overflows; an overflow is a design error.
- r_addr holds its last issued value when not issuing, since reads are side-effect free.
- Output stream:
  - pix_valid = FIFO non-empty; pix_data = FIFO head.
  - pix_data, pix_hcount, pix_vcount, pix_eol and pix_last stay stable while pix_valid & !pix_ready.
  - Handshake = pix_valid & pix_ready.
  - On each handshake, hcount increments. At IMG_WIDTH-1 it wraps to 0 and vcount increments. vcount wraps to 0 after pix_last.
- pix_last = (pix_hcount==IMG_WIDTH-1) & (pix_vcount==IMG_HEIGHT-1) & pix_valid.
- Latency and throughput (start accepted in cycle 0, w_busy=0, pix_ready=1):
  - Address 0 is issued in cycle 1 and its data is pushed in cycle 1+RD_LATENCY.
  - pix_valid first rises in cycle 2+RD_LATENCY.
  - Sustained rate is 1 pixel/cycle; the whole frame takes PIXELS+RD_LATENCY+2 cycles to done.
- Address arithmetic: r_addr = vcount_issue*IMG_WIDTH + hcount_issue, generated as a plain incrementing counter.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, RD_LATENCY=1, memory model returns data=address, pix_ready=1, start pulse at cycle 0:
  - -> 12 pixels with data 0..11 on consecutive cycles starting at cycle 3.
  - -> pix_eol on data 3, 7, 11; pix_last only on 11.
  - -> done pulse at cycle 15; busy high for cycles 1-14.
- Same parameters, w_busy=1 for 10 cycles around start -> state WAIT, no r_addr change and no pix_valid until w_busy falls; the frame is then identical to the first scenario.
- Backpressure: pix_ready toggles 1,0,0,1 repeating -> every pixel 0..11 delivered exactly once, in order. pix_data and counts stay stable during stalls, and the FIFO never exceeds FIFO_DEPTH.
- RD_LATENCY=3, FIFO_DEPTH=4, pix_ready=0 for 20 cycles then 1 -> exactly 4 reads issued (r_addr 0..3) before the stall, then in-order output 0..11.
- w_busy pulses for 5 cycles mid-READ after address 5 issued -> issuing pauses, in-flight data is kept, and the output sequence remains 0..11 with no duplicates.
- Async reset asserted while pixel 6 is pending -> pix_valid, busy, done and the counts go to 0 immediately. A new start then reads the frame from address 0.
